// File: rtl/proj1_read_cnt_pkg.sv
// Shared definitions for the project-1 counter stream: one-hot FSM encodings
// common to the counter writer and reader.
package proj1_read_cnt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'b001;
    localparam state_t RECV = 3'b010;
    localparam state_t DONE = 3'b100;

endpackage

// File: rtl/proj1_sync_fifo.sv
// Small synchronous FIFO with registered storage. The head entry is presented
// directly from the storage array.
module proj1_sync_fifo #(
    parameter int DATABIT    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [DATABIT-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [DATABIT-1:0] head_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATABIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/proj1_read_cnt.sv
// Receiver for the project-1 counter stream: checks beats against 1..N,
// counts beats and mismatches, and forwards accepted beats through a FIFO.
//
//   state | meaning
//   IDLE  | waiting for i_start; latches N and clears counters
//   RECV  | accepting beats while the FIFO has room
//   DONE  | one-cycle completion pulse, then back to IDLE
module proj1_read_cnt
    import proj1_read_cnt_pkg::*;
#(
    parameter int DATABIT    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic [DATABIT-1:0] i_num_cnt,
    input  logic               s_valid,
    input  logic [DATABIT-1:0] s_data,
    output logic               s_ready,
    output logic               m_valid,
    output logic [DATABIT-1:0] m_data,
    input  logic               m_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [DATABIT-1:0] o_rcv_cnt,
    output logic               o_err,
    output logic [DATABIT-1:0] o_err_cnt
);

    localparam logic [DATABIT-1:0] ONE = {{(DATABIT-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nx;
    logic [DATABIT-1:0] n_reg;
    logic [DATABIT-1:0] exp_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic               start;
    logic               accept;
    logic               pop;
    logic               last_beat;

    // s_ready looks only at the registered full flag; no m_ready path.
    assign s_ready   = (state == RECV) && !fifo_full;
    assign accept    = s_valid && s_ready;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign start     = (state == IDLE) && i_start;
    assign last_beat = accept && ((o_rcv_cnt + ONE) == n_reg);
    assign o_busy    = (state == RECV);
    assign o_done    = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = (i_num_cnt == '0) ? DONE : RECV;
            RECV:    if (last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            exp_reg   <= ONE;
            o_rcv_cnt <= '0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                n_reg     <= i_num_cnt;
                exp_reg   <= ONE;
                o_rcv_cnt <= '0;
                o_err     <= 1'b0;
                o_err_cnt <= '0;
            end else if (accept) begin
                o_rcv_cnt <= o_rcv_cnt + ONE;
                exp_reg   <= exp_reg + ONE;
                if (s_data != exp_reg) begin
                    o_err <= 1'b1;
                    if (o_err_cnt != '1) begin
                        o_err_cnt <= o_err_cnt + ONE;
                    end
                end
            end
        end
    end

    proj1_sync_fifo #(
        .DATABIT    (DATABIT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (accept),
        .push_data (s_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (m_data)
    );

endmodule

// File: tb/tb_proj1_read_cnt.sv
// Testbench for proj1_read_cnt: table of transactions plus hand-written
// backpressure and reset sequences, checked every cycle against a queue model.
module tb_proj1_read_cnt;

    localparam int DATABIT = 7;
    localparam int DEPTH   = 4;
    localparam int LIMIT   = 1000;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_start;
    logic [DATABIT-1:0] i_num_cnt;
    logic               s_valid;
    logic [DATABIT-1:0] s_data;
    logic               s_ready;
    logic               m_valid;
    logic [DATABIT-1:0] m_data;
    logic               m_ready;
    logic               o_busy;
    logic               o_done;
    logic [DATABIT-1:0] o_rcv_cnt;
    logic               o_err;
    logic [DATABIT-1:0] o_err_cnt;

    proj1_read_cnt #(
        .DATABIT    (DATABIT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (i_start),
        .i_num_cnt (i_num_cnt),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_rcv_cnt (o_rcv_cnt),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 receiving, 2 completion cycle.
    int ref_ph   = 0;
    int ref_n    = 0;
    int ref_rcv  = 0;
    int ref_err  = 0;
    int ref_errc = 0;
    int ref_q[$];

    typedef struct {
        int          n;
        logic [15:0] bad;
        bit          all_bad;
        bit          rnd;
        bit          poke;
        int          exp_rcv;
        int          exp_err;
        int          exp_errc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_ph   = 0;
        ref_n    = 0;
        ref_rcv  = 0;
        ref_err  = 0;
        ref_errc = 0;
        ref_q.delete();
    endtask

    // Compare outputs against the model, advance the model with the current
    // inputs, then move to the next falling edge.
    task automatic step();
        bit pop_m;
        bit acc_m;
        chk("s_ready", int'(s_ready), (ref_ph == 1 && ref_q.size() < DEPTH) ? 1 : 0);
        chk("m_valid", int'(m_valid), (ref_q.size() > 0) ? 1 : 0);
        if (ref_q.size() > 0) chk("m_data", int'(m_data), ref_q[0]);
        chk("o_busy", int'(o_busy), (ref_ph == 1) ? 1 : 0);
        chk("o_done", int'(o_done), (ref_ph == 2) ? 1 : 0);
        chk("o_rcv_cnt", int'(o_rcv_cnt), ref_rcv);
        chk("o_err", int'(o_err), ref_err);
        chk("o_err_cnt", int'(o_err_cnt), ref_errc);

        pop_m = (ref_q.size() > 0) && m_ready;
        acc_m = (ref_ph == 1) && (ref_q.size() < DEPTH) && s_valid;
        if (pop_m) void'(ref_q.pop_front());
        case (ref_ph)
            0: if (i_start) begin
                ref_n    = int'(i_num_cnt);
                ref_rcv  = 0;
                ref_err  = 0;
                ref_errc = 0;
                ref_ph   = (ref_n == 0) ? 2 : 1;
            end
            1: if (acc_m) begin
                ref_q.push_back(int'(s_data));
                ref_rcv++;
                if (int'(s_data) != ref_rcv) begin
                    ref_err = 1;
                    if (ref_errc < (1 << DATABIT) - 1) ref_errc++;
                end
                if (ref_rcv == ref_n) ref_ph = 2;
            end
            default: ref_ph = 0;
        endcase
        @(negedge clk);
    endtask

    function automatic logic [DATABIT-1:0] beat_val(input int idx, input logic [15:0] bad,
                                                    input bit all_bad);
        logic [DATABIT-1:0] v;
        bit corrupt;
        v = DATABIT'(idx);
        corrupt = all_bad || (idx >= 1 && idx <= 16 && bad[idx-1]);
        if (corrupt) v = v ^ 7'h40;
        return v;
    endfunction

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (DEPTH + 1) step();
    endtask

    task automatic run_txn(input int n, input logic [15:0] bad, input bit all_bad,
                           input bit rnd, input bit poke);
        int cyc;
        i_start   = 1'b1;
        i_num_cnt = DATABIT'(n);
        s_valid   = 1'b0;
        m_ready   = 1'b1;
        step();
        cyc = 0;
        while (ref_ph != 0 && cyc < LIMIT) begin
            i_start   = poke && (ref_ph == 1);
            i_num_cnt = poke ? 7'd2 : DATABIT'($urandom);
            s_valid   = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data    = beat_val(ref_rcv + 1, bad, all_bad);
            m_ready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            cyc++;
        end
        i_start = 1'b0;
        chk("txn_complete", (ref_ph == 0) ? 1 : 0, 1);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{5,   16'h0000, 1'b0, 1'b0, 1'b0, 5,   0, 0};
        vecs[1] = '{4,   16'h0004, 1'b0, 1'b0, 1'b0, 4,   1, 1};
        vecs[2] = '{0,   16'h0000, 1'b0, 1'b0, 1'b0, 0,   0, 0};
        vecs[3] = '{1,   16'h0000, 1'b0, 1'b0, 1'b0, 1,   0, 0};
        vecs[4] = '{10,  16'h0000, 1'b0, 1'b1, 1'b0, 10,  0, 0};
        vecs[5] = '{12,  16'h0801, 1'b0, 1'b1, 1'b0, 12,  1, 2};
        vecs[6] = '{5,   16'h0000, 1'b0, 1'b0, 1'b1, 5,   0, 0};
        vecs[7] = '{3,   16'h0007, 1'b0, 1'b1, 1'b0, 3,   1, 3};
        vecs[8] = '{127, 16'h0000, 1'b1, 1'b0, 1'b0, 127, 1, 127};

        reset_n   = 1'b0;
        i_start   = 1'b0;
        i_num_cnt = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        chk("rst_m_data", int'(m_data), 0);
        step();

        foreach (vecs[i]) begin
            run_txn(vecs[i].n, vecs[i].bad, vecs[i].all_bad, vecs[i].rnd, vecs[i].poke);
            chk($sformatf("vec%0d_rcv", i), int'(o_rcv_cnt), vecs[i].exp_rcv);
            chk($sformatf("vec%0d_err", i), int'(o_err), vecs[i].exp_err);
            chk($sformatf("vec%0d_errc", i), int'(o_err_cnt), vecs[i].exp_errc);
        end

        // Backpressure: N=8 with downstream stalled fills the FIFO at 4.
        i_start   = 1'b1;
        i_num_cnt = 7'd8;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        step();
        i_start = 1'b0;
        repeat (10) begin
            s_valid = 1'b1;
            s_data  = DATABIT'(ref_rcv + 1);
            m_ready = 1'b0;
            step();
        end
        chk("bp_rcv_stall", int'(o_rcv_cnt), 4);
        chk("bp_sready_stall", int'(s_ready), 0);
        chk("bp_mvalid_stall", int'(m_valid), 1);
        cyc = 0;
        while (ref_ph != 0 && cyc < 200) begin
            s_valid = 1'b1;
            s_data  = DATABIT'(ref_rcv + 1);
            m_ready = 1'b1;
            step();
            cyc++;
        end
        chk("bp_complete", (ref_ph == 0) ? 1 : 0, 1);
        drain();
        chk("bp_rcv_final", int'(o_rcv_cnt), 8);
        chk("bp_err_final", int'(o_err), 0);

        // Reset in the middle of an N=6 transaction with 3 beats buffered.
        i_start   = 1'b1;
        i_num_cnt = 7'd6;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        step();
        i_start = 1'b0;
        cyc = 0;
        while (ref_rcv < 3 && cyc < 50) begin
            s_valid = 1'b1;
            s_data  = DATABIT'(ref_rcv + 1);
            m_ready = 1'b0;
            step();
            cyc++;
        end
        chk("rst_mid_mvalid_before", int'(m_valid), 1);
        s_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_s_ready", int'(s_ready), 0);
        chk("rst_mid_m_valid", int'(m_valid), 0);
        chk("rst_mid_m_data", int'(m_data), 0);
        chk("rst_mid_busy", int'(o_busy), 0);
        chk("rst_mid_done", int'(o_done), 0);
        chk("rst_mid_rcv", int'(o_rcv_cnt), 0);
        chk("rst_mid_err", int'(o_err), 0);
        chk("rst_mid_errc", int'(o_err_cnt), 0);
        model_reset();
        @(negedge clk);
        chk("rst_hold_done", int'(o_done), 0);
        reset_n = 1'b1;
        step();
        run_txn(2, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("post_rst_rcv", int'(o_rcv_cnt), 2);
        chk("post_rst_err", int'(o_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
